// File: rtl/adsr_envelope_scaler.sv
// adsr_envelope_scaler
//   Applies a gate-driven ADSR envelope to the offset-binary sine sample coming
//   from sine_wave_generator and hands the amplitude-scaled sample to the mixer.
//   The envelope advances by one step on each sample_valid strobe. The scaled
//   sample appears two clocks after its strobe.
// Ports
//   clk, rst        system clock; asynchronous active-high reset
//   sine            unsigned SAMPLE_W-bit input sample (mid code 2**(SAMPLE_W-1))
//   sample_valid    one-cycle strobe: sine is valid and the envelope ticks
//   gate            note held level; rising edge = key on, falling edge = key off
//   attack_rate     level increment per tick while attacking
//   decay_rate      level decrement per tick while decaying
//   sustain_level   sustain target, scaled up to ENV_W bits
//   release_rate    level decrement per tick while releasing
//   sample_out      scaled offset-binary sample (holds between strobes)
//   out_valid       one-cycle strobe qualifying sample_out
//   env_level       current envelope level
//   env_state       IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//   active          high whenever env_state is not IDLE
module adsr_envelope_scaler #(
    parameter int SAMPLE_W = 11,
    parameter int ENV_W    = 12,
    parameter int RATE_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sine,
    input  logic                sample_valid,
    input  logic                gate,
    input  logic [RATE_W-1:0]   attack_rate,
    input  logic [RATE_W-1:0]   decay_rate,
    input  logic [7:0]          sustain_level,
    input  logic [RATE_W-1:0]   release_rate,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                out_valid,
    output logic [ENV_W-1:0]    env_level,
    output logic [2:0]          env_state,
    output logic                active
);

    localparam int MID     = 1 << (SAMPLE_W - 1);
    localparam int ENV_MAX = (1 << ENV_W) - 1;
    localparam int PW      = SAMPLE_W + ENV_W + 1;   // signed product width

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t                     state_reg, state_next;
    logic [ENV_W-1:0]           level_reg, level_next;
    logic                       gate_reg;
    logic                       rise, fall;
    logic [ENV_W-1:0]           target;
    logic [ENV_W:0]             attack_sum, decay_diff, release_diff;

    logic signed [SAMPLE_W:0]   s_next, s1_reg;
    logic [ENV_W-1:0]           e1_reg;
    logic                       v1_reg;
    logic signed [PW-1:0]       prod;
    logic signed [SAMPLE_W:0]   quot;
    logic [SAMPLE_W-1:0]        y;
    logic                       unused_bits;

    assign rise   = gate & ~gate_reg;
    assign fall   = ~gate & gate_reg;
    assign target = {sustain_level, {(ENV_W-8){1'b0}}};

    // One extra bit so an overflow (attack) or borrow (decay/release) is visible
    // in the MSB instead of wrapping.
    assign attack_sum   = {1'b0, level_reg} + {{(ENV_W+1-RATE_W){1'b0}}, attack_rate};
    assign decay_diff   = {1'b0, level_reg} - {{(ENV_W+1-RATE_W){1'b0}}, decay_rate};
    assign release_diff = {1'b0, level_reg} - {{(ENV_W+1-RATE_W){1'b0}}, release_rate};

    always_comb begin
        state_next = state_reg;
        level_next = level_reg;
        case (state_reg)
            IDLE: begin
                if (rise) state_next = ATTACK;
            end
            ATTACK: begin
                // A gate edge takes priority over a coincident tick; the level holds.
                if (fall) begin
                    state_next = RELEASE;
                end else if (sample_valid) begin
                    if (attack_sum >= (ENV_W+1)'(ENV_MAX)) begin
                        level_next = ENV_W'(ENV_MAX);
                        state_next = DECAY;
                    end else begin
                        level_next = attack_sum[ENV_W-1:0];
                    end
                end
            end
            DECAY: begin
                if (fall) begin
                    state_next = RELEASE;
                end else if (sample_valid) begin
                    if (decay_diff[ENV_W] || (decay_diff[ENV_W-1:0] <= target)) begin
                        level_next = target;
                        state_next = SUSTAIN;
                    end else begin
                        level_next = decay_diff[ENV_W-1:0];
                    end
                end
            end
            SUSTAIN: begin
                if (fall) begin
                    state_next = RELEASE;
                end else if (sample_valid) begin
                    level_next = target;
                end
            end
            RELEASE: begin
                // Retrigger continues from the current level.
                if (rise) begin
                    state_next = ATTACK;
                end else if (sample_valid) begin
                    if (release_diff[ENV_W] || (release_diff[ENV_W-1:0] == '0)) begin
                        level_next = '0;
                        state_next = IDLE;
                    end else begin
                        level_next = release_diff[ENV_W-1:0];
                    end
                end
            end
            default: begin
                state_next = IDLE;
                level_next = '0;
            end
        endcase
    end

    // Datapath: centre the sample around zero, multiply by the pre-update level
    // and take floor(p / 2**ENV_W), then re-bias to offset binary.
    assign s_next = signed'({1'b0, sine} - (SAMPLE_W+1)'(MID));
    assign prod   = PW'(s1_reg) * PW'(signed'({1'b0, e1_reg}));
    assign quot   = prod[ENV_W +: SAMPLE_W+1];           // arithmetic shift, floor
    assign y      = quot[SAMPLE_W-1:0] + SAMPLE_W'(MID);  // result always fits 0..2**SAMPLE_W-2
    assign unused_bits = ^{prod[ENV_W-1:0], prod[PW-1], quot[SAMPLE_W]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gate_reg   <= 1'b0;
            state_reg  <= IDLE;
            level_reg  <= '0;
            s1_reg     <= '0;
            e1_reg     <= '0;
            v1_reg     <= 1'b0;
            sample_out <= SAMPLE_W'(MID);
            out_valid  <= 1'b0;
        end else begin
            gate_reg  <= gate;
            state_reg <= state_next;
            level_reg <= level_next;
            v1_reg    <= sample_valid;
            if (sample_valid) begin
                s1_reg <= s_next;
                e1_reg <= level_reg;
            end
            out_valid <= v1_reg;
            if (v1_reg) sample_out <= y;
        end
    end

    assign env_level = level_reg;
    assign env_state = state_reg;
    assign active    = (state_reg != IDLE);

endmodule

// File: tb/tb_adsr_envelope_scaler.sv
module tb_adsr_envelope_scaler;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] sine;
    logic        sample_valid;
    logic        gate;
    logic [7:0]  attack_rate, decay_rate, sustain_level, release_rate;
    logic [10:0] sample_out;
    logic        out_valid;
    logic [11:0] env_level;
    logic [2:0]  env_state;
    logic        active;

    adsr_envelope_scaler dut (
        .clk(clk), .rst(rst), .sine(sine), .sample_valid(sample_valid), .gate(gate),
        .attack_rate(attack_rate), .decay_rate(decay_rate), .sustain_level(sustain_level),
        .release_rate(release_rate), .sample_out(sample_out), .out_valid(out_valid),
        .env_level(env_level), .env_state(env_state), .active(active)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: envelope as an integer level plus a named phase,
    // and the output as floor(centred_sample * level / 4096) + 1024.
    int m_state, m_level, m_gate;
    int m_s1, m_e1, m_v1, m_out, m_ov;

    typedef struct {
        logic [10:0] sine;
        int          exp0;
        int          expmax;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int scale(input int s, input int e);
        int p;
        p = s * e;
        if (p >= 0) return p / 4096 + 1024;
        return -((-p + 4095) / 4096) + 1024;
    endfunction

    task automatic model_reset();
        m_state = 0; m_level = 0; m_gate = 0;
        m_s1 = 0; m_e1 = 0; m_v1 = 0; m_out = 1024; m_ov = 0;
    endtask

    task automatic model_step();
        int  target;
        bit  rise, fall;
        target = int'(sustain_level) * 16;
        rise = gate && (m_gate == 0);
        fall = !gate && (m_gate == 1);
        if (m_v1 != 0) m_out = scale(m_s1, m_e1);
        m_ov = m_v1;
        m_v1 = sample_valid ? 1 : 0;
        if (sample_valid) begin
            m_s1 = int'(sine) - 1024;
            m_e1 = m_level;
        end
        case (m_state)
            0: if (rise) m_state = 1;
            1: if (fall) m_state = 4;
               else if (sample_valid) begin
                   m_level = m_level + int'(attack_rate);
                   if (m_level >= 4095) begin m_level = 4095; m_state = 2; end
               end
            2: if (fall) m_state = 4;
               else if (sample_valid) begin
                   m_level = m_level - int'(decay_rate);
                   if (m_level <= target) begin m_level = target; m_state = 3; end
               end
            3: if (fall) m_state = 4;
               else if (sample_valid) m_level = target;
            default: if (rise) m_state = 1;
               else if (sample_valid) begin
                   m_level = m_level - int'(release_rate);
                   if (m_level <= 0) begin m_level = 0; m_state = 0; end
               end
        endcase
        m_gate = gate ? 1 : 0;
    endtask

    task automatic compare_all();
        check("env_level", int'(env_level), m_level);
        check("env_state", int'(env_state), m_state);
        check("active", int'(active), (m_state != 0) ? 1 : 0);
        check("out_valid", int'(out_valid), m_ov);
        check("sample_out", int'(sample_out), m_out);
    endtask

    // One clock: model advances on the edge, DUT is sampled 1 ns later,
    // and control returns at the falling edge where new inputs are driven.
    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic tick4();
        sample_valid = 1'b1;
        cyc();
        sample_valid = 1'b0;
        cyc(); cyc(); cyc();
    endtask

    task automatic strobe_and_wait(input logic [10:0] s);
        sine = s;
        sample_valid = 1'b1;
        cyc();
        sample_valid = 1'b0;
        cyc();
    endtask

    initial begin
        vecs[0] = '{11'd2047, 1024, 2046};
        vecs[1] = '{11'd0,    1024, 0};
        vecs[2] = '{11'd1024, 1024, 1024};
        vecs[3] = '{11'd1536, 1024, 1535};
        vecs[4] = '{11'd512,  1024, 512};
        vecs[5] = '{11'd1025, 1024, 1024};
        vecs[6] = '{11'd1023, 1024, 1023};

        rst = 1'b1; sine = '0; sample_valid = 1'b0; gate = 1'b0;
        attack_rate = '0; decay_rate = '0; sustain_level = '0; release_rate = '0;
        model_reset();
        @(negedge clk); @(negedge clk);
        check("reset_state", int'(env_state), 0);
        check("reset_level", int'(env_level), 0);
        check("reset_sample", int'(sample_out), 1024);
        check("reset_valid", int'(out_valid), 0);
        check("reset_active", int'(active), 0);
        rst = 1'b0;

        // Two-cycle latency with the envelope idle.
        sine = 11'd2047;
        sample_valid = 1'b1;
        cyc();
        sample_valid = 1'b0;
        check("latency_n1_valid", int'(out_valid), 0);
        cyc();
        check("latency_n2_valid", int'(out_valid), 1);
        check("latency_n2_sample", int'(sample_out), 1024);
        check("latency_n2_state", int'(env_state), 0);
        cyc();
        check("valid_one_cycle", int'(out_valid), 0);

        foreach (vecs[i]) begin
            strobe_and_wait(vecs[i].sine);
            check($sformatf("env0_vec%0d", i), int'(sample_out), vecs[i].exp0);
        end

        // Attack at 255 per tick, saturating on tick 17.
        attack_rate = 8'd255; decay_rate = 8'd0; sustain_level = 8'd128;
        gate = 1'b1;
        cyc();
        check("attack_enter", int'(env_state), 1);
        for (int k = 1; k <= 17; k++) begin
            tick4();
            check($sformatf("attack_tick%0d", k), int'(env_level), (k < 17) ? 255 * k : 4095);
        end
        check("attack_to_decay", int'(env_state), 2);

        // Full-scale envelope held by a zero decay rate.
        foreach (vecs[i]) begin
            strobe_and_wait(vecs[i].sine);
            check($sformatf("envmax_vec%0d", i), int'(sample_out), vecs[i].expmax);
        end
        check("decay_rate0_hold", int'(env_level), 4095);

        decay_rate = 8'd100;
        for (int k = 1; k <= 21; k++) begin
            tick4();
            check($sformatf("decay_tick%0d", k), int'(env_level), (k < 21) ? 4095 - 100 * k : 2048);
        end
        check("decay_to_sustain", int'(env_state), 3);

        sustain_level = 8'd64;
        tick4();
        check("sustain_follow", int'(env_level), 1024);

        gate = 1'b0;
        cyc();
        check("release_enter", int'(env_state), 4);
        check("release_no_jump", int'(env_level), 1024);
        release_rate = 8'd255;
        for (int k = 1; k <= 5; k++) begin
            tick4();
            check($sformatf("release_tick%0d", k), int'(env_level), (1024 - 255 * k > 0) ? 1024 - 255 * k : 0);
        end
        check("release_to_idle", int'(env_state), 0);
        check("release_inactive", int'(active), 0);

        // Retrigger from level 1000 with a coincident tick.
        attack_rate = 8'd200;
        gate = 1'b1;
        cyc();
        for (int k = 1; k <= 5; k++) tick4();
        check("retrig_build", int'(env_level), 1000);
        gate = 1'b0;
        release_rate = 8'd0;
        cyc();
        check("retrig_in_release", int'(env_state), 4);
        attack_rate = 8'd7;
        gate = 1'b1;
        sample_valid = 1'b1;
        cyc();
        sample_valid = 1'b0;
        check("retrig_state", int'(env_state), 1);
        check("retrig_level_hold", int'(env_level), 1000);
        tick4();
        check("retrig_from_level", int'(env_level), 1007);
        gate = 1'b0;
        sample_valid = 1'b1;
        cyc();
        sample_valid = 1'b0;
        check("fall_tick_state", int'(env_state), 4);
        check("fall_tick_level", int'(env_level), 1007);

        // Asynchronous reset while attacking, with a live output pulse.
        gate = 1'b1;
        cyc();
        check("midattack_state", int'(env_state), 1);
        strobe_and_wait(11'd2047);
        check("pre_reset_valid", int'(out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_state", int'(env_state), 0);
        check("async_rst_level", int'(env_level), 0);
        check("async_rst_sample", int'(sample_out), 1024);
        check("async_rst_valid", int'(out_valid), 0);
        check("async_rst_active", int'(active), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Randomized run against the model.
        for (int n = 0; n < 4000; n++) begin
            sample_valid = ($urandom_range(0, 2) == 0);
            sine = 11'($urandom_range(0, 2047));
            if ($urandom_range(0, 99) == 0) gate = ~gate;
            if ($urandom_range(0, 149) == 0) attack_rate  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            if ($urandom_range(0, 149) == 0) decay_rate   = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            if ($urandom_range(0, 149) == 0) release_rate = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            if ($urandom_range(0, 99) == 0)  sustain_level = 8'($urandom);
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
